control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Minimal sequential instruction engine for the DAQ firmware. It fetches 32-bit
//  instruction words from a word-organised memory over a simple read/write
//  request port, decodes them and executes them against an internal 8x32 register file.
//  It sits between the system clock domain and the shared control/config memory.
// PARAMETERS
//  ADDR_W    17        byte-address width of memory_addr
//  DATA_W    32        instruction/data word width
//  RESET_PC  17'h0     fetch address after reset (word aligned)
// PORTS
//  clk               in   1   system clock; all state changes on rising edge
//  reset             in   1   reset, asynchronous, active-low
//  memory_read_req   out  1   one-cycle read strobe
//  memory_write_req  out  1   one-cycle write strobe
//  memory_addr       out  17  byte address; bits[1:0] always 0
//  memory_data_o     out  32  write data, valid with memory_write_req
//  memory_data_i     in   32  read data, valid the cycle after memory_read_req
//  memory_busy       in   1   memory stall; high = response not yet valid
// BEHAVIOUR
//  Reset (reset low, async): PC=RESET_PC; regs r0..r7=0; state=FETCH;
//   memory_read_req=0, memory_write_req=0, memory_addr=0, memory_data_o=0.
//  Encoding: [31:28] op, [27:25] a, [24:22] b, [21:19] c, [16:0] imm.
//   0x0 NOP; 0x1 LDI ra=zext(imm[15:0]); 0x2 LD ra=mem[imm]; 0x3 ST mem[imm]=ra;
//   0x4 ADD ra=rb+rc; 0x5 SUB ra=rb-rc; 0x6 AND; 0x7 OR; 0x8 XOR (ra=rb op rc);
//   0x9 JMP PC=imm; 0xA BEQZ if ra==0 PC=imm; 0xF HALT; other opcodes = NOP.
//  Arithmetic: 32-bit modulo 2^32, no flags. r0 is an ordinary register.
//  Addresses: imm[1:0] forced to 0 on memory_addr; PC advances +4, wraps 17'h1FFFC->0.
//  States: FETCH -> FWAIT -> EXEC -> (MREQ -> MWAIT ->) FETCH; HALT is terminal.
//   FETCH: read_req=1, addr=PC for exactly one cycle.
//   FWAIT: strobes low; when memory_busy=0 latch memory_data_i as IR, go EXEC;
//          if busy=1 stay (any number of cycles).
//   EXEC: ALU/LDI/branch writeback, PC update; LD/ST -> MREQ, HALT -> HALT, else FETCH.
//   MREQ: LD: read_req=1, addr=imm; ST: write_req=1, addr=imm, data_o=ra. One cycle.
//   MWAIT: wait memory_busy=0; LD latches memory_data_i into ra; then FETCH.
//  Latency: non-memory op 3 cycles, LD/ST 5 cycles (plus busy stall cycles).
//  Strobes never both high; never high two consecutive cycles; addr/data_o
//   held stable between requests.
//  Write-after-read hazards impossible: strictly one instruction in flight.
//  HALT: strobes stay 0 forever until reset. Reset mid-instruction aborts it;
//   no partial register write; restart at RESET_PC.
// TESTING
//  ALU: LDI r1,5; LDI r2,3; ADD r3,r1,r2; ST r3,0x100; HALT -> mem[0x40]=8,
//   write_req seen once with addr=0x100, data_o=8.
//  Load/sub: mem[0x41]=10; LD r1,0x104; LDI r2,4; SUB r3,r1,r2; ST r3,0x108
//   -> mem[0x42]=6; LD takes 5 cycles with busy held 0.
//  Branch: LDI r1,0; BEQZ r1,0x20; ST at 0x10 skipped; ST at 0x20 executes
//   -> only target store appears; JMP to self loops fetch at constant addr.
//  Busy stall: hold memory_busy=1 3 cycles in FWAIT -> no new strobe until
//   busy drops; IR captured from data_i at first busy=0 cycle.
//  Wrap/overflow: LDI r1,0xFFFF; chained ADD reaching 0xFFFFFFFF then +1 -> 0;
//   PC at 0x1FFFC with NOP fetches 0x00000 next.
//  Reset: assert reset low during MREQ of ST -> strobes 0 immediately,
//   no write occurs, first fetch after release at addr 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: minimal sequential instruction engine.
//
// Fetches 32-bit instruction words from a word-organised memory and runs them one at a time
// against an internal 8x32 register file. Exactly one instruction is in flight at any time.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   memory_read_req   one-cycle read strobe (instruction fetch or LD)
//   memory_write_req  one-cycle write strobe (ST)
//   memory_addr       byte address, bits [1:0] always zero
//   memory_data_o     write data, valid with memory_write_req
//   memory_data_i     read data, valid the cycle after memory_read_req once memory_busy is low
//   memory_busy       high while the memory response is not yet valid
//
// Instruction word: [31:28] op, [27:25] a, [24:22] b, [21:19] c, [16:0] imm.
// Sequence: FETCH -> FWAIT -> EXEC -> (MREQ -> MWAIT ->) FETCH; HALT is terminal.

module control_unit #(
  parameter int unsigned          ADDR_W   = 17,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              memory_read_req,
  output logic              memory_write_req,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [DATA_W-1:0] memory_data_o,
  input  logic [DATA_W-1:0] memory_data_i,
  input  logic              memory_busy
);

  // Opcodes; anything not listed executes as a NOP.
  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdi  = 4'h1;
  localparam logic [3:0] OpLd   = 4'h2;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpAnd  = 4'h6;
  localparam logic [3:0] OpOr   = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpJmp  = 4'h9;
  localparam logic [3:0] OpBeqz = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StFwait,
    StExec,
    StMreq,
    StMwait,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  // Last issued address/data, so the bus stays stable between requests.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] regs_q [8];

  // Register file write port, driven from EXEC (ALU/LDI) and MWAIT (LD).
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  // Bus values before the reset gate.
  logic              read_req_c;
  logic              write_req_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;

  // Instruction fields.
  logic [3:0]        op;
  logic [2:0]        ra_idx, rb_idx, rc_idx;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] ra_val, rb_val, rc_val;
  logic [DATA_W-1:0] ldi_val;
  logic [DATA_W-1:0] alu_res;

  assign op      = ir_q[31:28];
  assign ra_idx  = ir_q[27:25];
  assign rb_idx  = ir_q[24:22];
  assign rc_idx  = ir_q[21:19];
  // Immediate used as an address (LD/ST/JMP/BEQZ) is always word aligned.
  assign ea      = {ir_q[ADDR_W-1:2], 2'b00};
  assign ldi_val = {{(DATA_W-16){1'b0}}, ir_q[15:0]};
  assign ra_val  = regs_q[ra_idx];
  assign rb_val  = regs_q[rb_idx];
  assign rc_val  = regs_q[rc_idx];

  // Bits [18:17] of the instruction word carry no meaning.
  logic unused_ir_pad;
  assign unused_ir_pad = ^ir_q[18:17];

  // Two-operand ALU, modulo 2^DATA_W, no flags.
  always_comb begin
    alu_res = '0;
    case (op)
      OpAdd:   alu_res = rb_val + rc_val;
      OpSub:   alu_res = rb_val - rc_val;
      OpAnd:   alu_res = rb_val & rc_val;
      OpOr:    alu_res = rb_val | rc_val;
      OpXor:   alu_res = rb_val ^ rc_val;
      default: alu_res = '0;
    endcase
  end

  // Next-state, register-file write and bus drive.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    addr_d      = addr_q;
    data_d      = data_q;
    read_req_c  = 1'b0;
    write_req_c = 1'b0;
    addr_c      = addr_q;
    data_c      = data_q;
    rf_we       = 1'b0;
    rf_waddr    = ra_idx;
    rf_wdata    = alu_res;

    unique case (state_q)
      StFetch: begin
        read_req_c = 1'b1;
        addr_c     = pc_q;
        addr_d     = pc_q;
        state_d    = StFwait;
      end

      StFwait: begin
        if (!memory_busy) begin
          ir_d    = memory_data_i;
          state_d = StExec;
        end
      end

      StExec: begin
        // 17-bit add wraps 0x1FFFC -> 0x00000 on its own.
        pc_d    = pc_q + ADDR_W'(4);
        state_d = StFetch;
        case (op)
          OpLdi: begin
            rf_we    = 1'b1;
            rf_wdata = ldi_val;
          end
          OpLd, OpSt:                       state_d = StMreq;
          OpAdd, OpSub, OpAnd, OpOr, OpXor: rf_we   = 1'b1;
          OpJmp:                            pc_d    = ea;
          OpBeqz: begin
            if (ra_val == '0) begin
              pc_d = ea;
            end
          end
          OpHalt:                           state_d = StHalt;
          default:                          ;
        endcase
      end

      StMreq: begin
        addr_c  = ea;
        addr_d  = ea;
        state_d = StMwait;
        if (op == OpSt) begin
          write_req_c = 1'b1;
          data_c      = ra_val;
          data_d      = ra_val;
        end else begin
          read_req_c = 1'b1;
        end
      end

      StMwait: begin
        if (!memory_busy) begin
          state_d = StFetch;
          if (op == OpLd) begin
            rf_we    = 1'b1;
            rf_wdata = memory_data_i;
          end
        end
      end

      StHalt: ;

      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      if (rf_we) begin
        regs_q[rf_waddr] <= rf_wdata;
      end
    end
  end

  // FETCH is the reset state, so the bus is forced quiet while reset is held; this also
  // kills an in-progress strobe the moment reset is asserted.
  assign memory_read_req  = reset & read_req_c;
  assign memory_write_req = reset & write_req_c;
  assign memory_addr      = reset ? addr_c : '0;
  assign memory_data_o    = reset ? data_c : '0;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: memory model on the bus, ISA-level reference interpreter,
// directed programs plus randomised programs.

module tb_control_unit;

  localparam logic [3:0] INop = 4'h0, ILdi = 4'h1, ILd = 4'h2, ISt = 4'h3, IAdd = 4'h4;
  localparam logic [3:0] ISub = 4'h5, IAnd = 4'h6, IOr = 4'h7, IXor = 4'h8, IJmp = 4'h9;
  localparam logic [3:0] IBeqz = 4'hA, IHalt = 4'hF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_read_req;
  logic        memory_write_req;
  logic [16:0] memory_addr;
  logic [31:0] memory_data_o;
  logic [31:0] memory_data_i;
  logic        memory_busy = 1'b0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk              (clk),
    .reset            (reset),
    .memory_read_req  (memory_read_req),
    .memory_write_req (memory_write_req),
    .memory_addr      (memory_addr),
    .memory_data_o    (memory_data_o),
    .memory_data_i    (memory_data_i),
    .memory_busy      (memory_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem  [32768];
  logic [31:0] mref [32768];
  logic [31:0] rdata = 32'h0;

  // A HALT word while busy: an early capture would stop the program visibly.
  assign memory_data_i = memory_busy ? 32'hF000_0000 : rdata;

  always @(posedge clk) begin
    if (memory_write_req) mem[memory_addr[16:2]] <= memory_data_o;
    if (memory_read_req)  rdata <= mem[memory_addr[16:2]];
  end

  // Busy generation: optional one-shot 3-cycle stall after the first fetch, optional random.
  bit busy_rand = 1'b0;
  bit stall_en  = 1'b0;
  bit stall_used = 1'b0;
  int stall_left = 0;

  always @(posedge clk) begin
    if (!reset) begin
      stall_left  <= 0;
      stall_used  <= 1'b0;
      memory_busy <= 1'b0;
    end else if (stall_en && !stall_used && memory_read_req) begin
      stall_used  <= 1'b1;
      stall_left  <= 3;
      memory_busy <= 1'b1;
    end else if (stall_left > 1) begin
      stall_left <= stall_left - 1;
    end else begin
      stall_left  <= 0;
      memory_busy <= busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    bit          wr;
    logic [16:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  bit  prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && (memory_read_req || memory_write_req)) begin
      check("strobe_exclusive", 64'(memory_read_req & memory_write_req), 64'(0));
      check("strobe_gap", 64'(prev_strobe), 64'(0));
      obs_q.push_back('{wr: memory_write_req, addr: memory_addr, data: memory_data_o, cyc: cyc});
    end
    prev_strobe <= reset && (memory_read_req || memory_write_req);
  end

  // ---------------- program helpers ----------------
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c,
                                      input logic [16:0] imm);
    return {op, a, b, c, 2'b00, imm};
  endfunction

  task automatic put(input logic [14:0] idx, input logic [31:0] v);
    mem[idx] <= v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] <= 32'h0;
  endtask

  // ISA-level interpreter over a copy of memory: one bus event per fetch / LD / ST with its
  // expected cycle offset (3 cycles per instruction, 5 for LD/ST, no stalls).
  task automatic build_expected(input int max_ev, output bit halted);
    logic [31:0] r [8];
    logic [31:0] ir;
    logic [16:0] pc, npc, ea;
    logic [2:0]  a, b, c;
    int          t;
    for (int i = 0; i < 32768; i++) mref[i] = mem[i];
    for (int i = 0; i < 8; i++) r[i] = 32'h0;
    pc = 17'h0;
    t = 0;
    halted = 1'b0;
    exp_q.delete();
    while (!halted && exp_q.size() < max_ev) begin
      ir = mref[pc[16:2]];
      exp_q.push_back('{wr: 1'b0, addr: pc, data: 32'h0, cyc: t});
      a = ir[27:25];
      b = ir[24:22];
      c = ir[21:19];
      ea = ir[16:0] & 17'h1FFFC;
      npc = pc + 17'd4;
      t += 3;
      case (ir[31:28])
        ILdi: r[a] = {16'h0, ir[15:0]};
        ILd: begin
          exp_q.push_back('{wr: 1'b0, addr: ea, data: 32'h0, cyc: t});
          r[a] = mref[ea[16:2]];
          t += 2;
        end
        ISt: begin
          exp_q.push_back('{wr: 1'b1, addr: ea, data: r[a], cyc: t});
          mref[ea[16:2]] = r[a];
          t += 2;
        end
        IAdd:  r[a] = r[b] + r[c];
        ISub:  r[a] = r[b] - r[c];
        IAnd:  r[a] = r[b] & r[c];
        IOr:   r[a] = r[b] | r[c];
        IXor:  r[a] = r[b] ^ r[c];
        IJmp:  npc = ea;
        IBeqz: if (r[a] == 32'h0) npc = ea;
        IHalt: halted = 1'b1;
        default: ;
      endcase
      pc = npc;
    end
  endtask

  task automatic run_prog(input string name, input int max_ev, input bit timing,
                          input int stall_extra);
    bit halted;
    int n;
    int extra;
    #1;
    build_expected(max_ev, halted);
    reset = 1'b0;
    obs_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, 64'(n < 3000), 64'(1));
    repeat (20) @(posedge clk);
    @(negedge clk);
    if (halted) check({name, "_event_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s[%0d].kind", name, i), 64'(obs_q[i].wr), 64'(exp_q[i].wr));
      check($sformatf("%s[%0d].addr", name, i), 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      if (exp_q[i].wr)
        check($sformatf("%s[%0d].data", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
      if (timing) begin
        extra = (i > 0) ? stall_extra : 0;
        check($sformatf("%s[%0d].cycle", name, i), 64'(obs_q[i].cyc - obs_q[0].cyc),
              64'(exp_q[i].cyc + extra));
      end
    end
  endtask

  task automatic load_alu();
    clear_mem();
    put(15'd0, enc(ILdi, 3'd1, 3'd0, 3'd0, 17'd5));
    put(15'd1, enc(ILdi, 3'd2, 3'd0, 3'd0, 17'd3));
    put(15'd2, enc(IAdd, 3'd3, 3'd1, 3'd2, 17'd0));
    put(15'd3, enc(ISt,  3'd3, 3'd0, 3'd0, 17'h100));
    put(15'd4, enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
  endtask

  task automatic gen_random(input int n);
    logic [3:0]  op;
    logic [16:0] imm;
    int          sel, tgt;
    clear_mem();
    for (int k = 0; k < 16; k++) put(15'(17'h400 + k), $urandom);
    for (int k = 0; k < n - 1; k++) begin
      sel = $urandom_range(0, 12);
      imm = 17'($urandom);
      case (sel)
        0:  op = INop;
        1, 12: op = ILdi;
        2:  op = ILd;
        3:  op = ISt;
        4:  op = IAdd;
        5:  op = ISub;
        6:  op = IAnd;
        7:  op = IOr;
        8:  op = IXor;
        9:  op = IJmp;
        10: op = IBeqz;
        default: op = 4'(11 + $urandom_range(0, 3));
      endcase
      if (op == ILd || op == ISt) imm = 17'(17'h1000 + 4 * $urandom_range(0, 15) +
                                             $urandom_range(0, 3));
      if (op == IJmp || op == IBeqz) begin
        tgt = k + 1 + $urandom_range(0, 3);
        if (tgt > n - 1) tgt = n - 1;
        imm = 17'(4 * tgt + $urandom_range(0, 3));
      end
      put(15'(k), enc(op, 3'($urandom), 3'($urandom), 3'($urandom), imm) |
                  (32'($urandom_range(0, 3)) << 17));
    end
    put(15'(n - 1), enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit found;
    int n;

    // Reset state of the bus.
    reset = 1'b0;
    #1;
    check("reset_read_req",  64'(memory_read_req),  64'(0));
    check("reset_write_req", 64'(memory_write_req), 64'(0));
    check("reset_addr",      64'(memory_addr),      64'(0));
    check("reset_data_o",    64'(memory_data_o),    64'(0));

    // ALU: 5 + 3 stored at 0x100.
    load_alu();
    run_prog("alu", 100, 1'b1, 0);
    check("alu_mem40", 64'(mem[15'h40]), 64'h8);

    // Load / subtract: 10 - 4 stored at 0x108, LD latency covered by cycle checks.
    clear_mem();
    put(15'h41, 32'd10);
    put(15'd0, enc(ILd,  3'd1, 3'd0, 3'd0, 17'h104));
    put(15'd1, enc(ILdi, 3'd2, 3'd0, 3'd0, 17'd4));
    put(15'd2, enc(ISub, 3'd3, 3'd1, 3'd2, 17'd0));
    put(15'd3, enc(ISt,  3'd3, 3'd0, 3'd0, 17'h108));
    put(15'd4, enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
    run_prog("ldsub", 100, 1'b1, 0);
    check("ldsub_mem42", 64'(mem[15'h42]), 64'h6);

    // Branch taken: store at 0x10 skipped, store at 0x24 executes.
    clear_mem();
    put(15'h80, 32'h0000_AAAA);
    put(15'd0, enc(ILdi,  3'd1, 3'd0, 3'd0, 17'd0));
    put(15'd1, enc(IBeqz, 3'd1, 3'd0, 3'd0, 17'h20));
    put(15'd4, enc(ISt,   3'd1, 3'd0, 3'd0, 17'h200));
    put(15'd5, enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
    put(15'd8, enc(ILdi,  3'd2, 3'd0, 3'd0, 17'd7));
    put(15'd9, enc(ISt,   3'd2, 3'd0, 3'd0, 17'h204));
    put(15'd10, enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
    run_prog("branch", 100, 1'b1, 0);
    check("branch_skipped", 64'(mem[15'h80]), 64'h0000_AAAA);
    check("branch_target",  64'(mem[15'h81]), 64'h7);

    // JMP to self: fetches repeat at address 0 every 3 cycles.
    clear_mem();
    put(15'd0, enc(IJmp, 3'd0, 3'd0, 3'd0, 17'd0));
    run_prog("jmpself", 6, 1'b1, 0);

    // Busy held 3 cycles in the first FWAIT: everything after shifts by 3.
    load_alu();
    stall_en = 1'b1;
    run_prog("stall", 100, 1'b1, 3);
    stall_en = 1'b0;
    check("stall_mem40", 64'(mem[15'h40]), 64'h8);

    // 32-bit wrap: 0xFFFF doubled-plus-one 16 times is 0xFFFFFFFF, +1 wraps to 0.
    clear_mem();
    n = 0;
    put(15'(n++), enc(ILdi, 3'd1, 3'd0, 3'd0, 17'hFFFF));
    put(15'(n++), enc(ILdi, 3'd3, 3'd0, 3'd0, 17'd1));
    for (int k = 0; k < 16; k++) begin
      put(15'(n++), enc(IAdd, 3'd1, 3'd1, 3'd1, 17'd0));
      put(15'(n++), enc(IAdd, 3'd1, 3'd1, 3'd3, 17'd0));
    end
    put(15'(n++), enc(ISt,  3'd1, 3'd0, 3'd0, 17'h300));
    put(15'(n++), enc(IAdd, 3'd1, 3'd1, 3'd3, 17'd0));
    put(15'(n++), enc(ISt,  3'd1, 3'd0, 3'd0, 17'h304));
    put(15'(n++), enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
    run_prog("ovf", 200, 1'b1, 0);
    check("ovf_all_ones", 64'(mem[15'hC0]), 64'hFFFF_FFFF);
    check("ovf_wrapped",  64'(mem[15'hC1]), 64'h0);

    // PC wrap: branch to 0x1FFFC, its successor is fetched from 0x00000.
    clear_mem();
    put(15'd0, enc(IBeqz, 3'd2, 3'd0, 3'd0, 17'h1FFFC));
    put(15'h7FFF, enc(ILdi, 3'd2, 3'd0, 3'd0, 17'd1));
    put(15'd1, enc(ISt, 3'd2, 3'd0, 3'd0, 17'h400));
    put(15'd2, enc(IHalt, 3'd0, 3'd0, 3'd0, 17'd0));
    run_prog("pcwrap", 100, 1'b1, 0);
    check("pcwrap_mem100", 64'(mem[15'h100]), 64'h1);

    // Random programs: one with exact timing, one under random busy stalls.
    gen_random(24);
    run_prog("rand0", 300, 1'b1, 0);
    gen_random(32);
    busy_rand = 1'b1;
    run_prog("rand1", 300, 1'b0, 0);
    busy_rand = 1'b0;

    // Reset asserted during the ST request: no write, bus quiet at once, restart at 0.
    load_alu();
    put(15'h40, 32'h1234_5678);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    found = 1'b0;
    n = 0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (memory_write_req) found = 1'b1;
    end
    check("rst_reached_store", 64'(found), 64'(1));
    reset = 1'b0;
    #1;
    check("rst_read_req",  64'(memory_read_req),  64'(0));
    check("rst_write_req", 64'(memory_write_req), 64'(0));
    check("rst_addr",      64'(memory_addr),      64'(0));
    check("rst_data_o",    64'(memory_data_o),    64'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst_no_write", 64'(mem[15'h40]), 64'h1234_5678);
    reset = 1'b1;
    #1;
    check("rst_first_fetch_req",  64'(memory_read_req), 64'(1));
    check("rst_first_fetch_addr", 64'(memory_addr),     64'(0));
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rst_restart_result", 64'(mem[15'h40]), 64'h8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
